// File: rtl/truth_table_sequencer.sv
// Exhaustive stimulus sequencer for small combinational blocks: sweeps every input
// vector, holds it for HOLD_CYCLES, samples the outputs and checks them against a golden table.
module truth_table_sequencer #(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned N_OUT       = 2,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [(2**N_IN)*N_OUT-1:0]    exp_table,
  input  logic [N_OUT-1:0]              dut_out,
  output logic [N_IN-1:0]               dut_in,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [N_IN:0]                 err_cnt,
  output logic [N_IN-1:0]               first_fail,
  output logic                          fail_seen
);

  localparam int unsigned TBL_W  = (2**N_IN) * N_OUT;
  localparam int unsigned IDX_W  = (TBL_W > 1) ? $clog2(TBL_W) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned ERR_W  = N_IN + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
  logic [N_IN-1:0]     dut_in_n;
  logic                busy_n, done_n, pass_n, fail_seen_n;
  logic [ERR_W-1:0]    err_cnt_n;
  logic [N_IN-1:0]     first_fail_n;
  logic [IDX_W-1:0]    exp_base;
  logic [N_OUT-1:0]    exp_slice;
  logic                mismatch;

  // dut_in doubles as the vector counter; select its golden slice
  always_comb begin
    exp_base  = IDX_W'(dut_in) * IDX_W'(N_OUT);
    exp_slice = exp_table[exp_base +: N_OUT];
    mismatch  = (dut_out != exp_slice);
  end

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_n      = state;
    hold_cnt_n   = hold_cnt;
    dut_in_n     = dut_in;
    busy_n       = busy;
    done_n       = done;
    pass_n       = pass;
    err_cnt_n    = err_cnt;
    first_fail_n = first_fail;
    fail_seen_n  = fail_seen;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = APPLY;
          hold_cnt_n   = '0;
          dut_in_n     = '0;
          busy_n       = 1'b1;
          done_n       = 1'b0;
          pass_n       = 1'b0;
          err_cnt_n    = '0;
          first_fail_n = '0;
          fail_seen_n  = 1'b0;
        end
      end

      APPLY: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_cnt_n = '0;
          if (mismatch) begin
            err_cnt_n = err_cnt + ERR_W'(1);
            if (!fail_seen) begin
              first_fail_n = dut_in;
              fail_seen_n  = 1'b1;
            end
          end
          if (dut_in != {N_IN{1'b1}}) begin
            dut_in_n = dut_in + N_IN'(1);
          end else begin
            // Final vector: pass reflects the count including this sample
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_cnt_n == '0);
          end
        end else begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
      fail_seen  <= 1'b0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      dut_in     <= dut_in_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_cnt    <= err_cnt_n;
      first_fail <= first_fail_n;
      fail_seen  <= fail_seen_n;
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Scoreboard bench: two sequencer builds (hold 2 and hold 1) driving a behavioural
// f1=a^b, f2=c&d block, checked against a table-walking reference model.
module tb_truth_table_sequencer;

  localparam int NV = 16;

  typedef struct {
    int which;
    int err;
    int ff;
    int pass;
    int fs;
    int done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start      [2];
  logic [31:0] exp_table  [2];
  logic [1:0]  dut_out    [2];
  logic [3:0]  dut_in     [2];
  logic        busy       [2];
  logic        done       [2];
  logic        pass       [2];
  logic [4:0]  err_cnt    [2];
  logic [3:0]  first_fail [2];
  logic        fail_seen  [2];

  int   cyc = 0;
  int   c0 [2];
  int   compared = 0;
  int   mismatched = 0;
  logic done_q [2];
  exp_t sbq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] golden(input logic [3:0] v);
    return {v[3] ^ v[2], v[1] & v[0]};
  endfunction

  function automatic logic [31:0] golden_table();
    logic [31:0] t;
    t = '0;
    for (int k = 0; k < NV; k++) t[k*2 +: 2] = golden(4'(k));
    return t;
  endfunction

  function automatic int hold(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  assign dut_out[0] = golden(dut_in[0]);
  assign dut_out[1] = golden(dut_in[1]);

  truth_table_sequencer #(.N_IN(4), .N_OUT(2), .HOLD_CYCLES(2)) u_dut_h2 (
    .clk(clk), .rst(rst), .start(start[0]), .exp_table(exp_table[0]),
    .dut_out(dut_out[0]), .dut_in(dut_in[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_cnt(err_cnt[0]), .first_fail(first_fail[0]),
    .fail_seen(fail_seen[0])
  );

  truth_table_sequencer #(.N_IN(4), .N_OUT(2), .HOLD_CYCLES(1)) u_dut_h1 (
    .clk(clk), .rst(rst), .start(start[1]), .exp_table(exp_table[1]),
    .dut_out(dut_out[1]), .dut_in(dut_in[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_cnt(err_cnt[1]), .first_fail(first_fail[1]),
    .fail_seen(fail_seen[1])
  );

  task automatic check(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: walk the table against the golden function, record the predicted result
  task automatic launch(input int d, input logic [31:0] tbl, input bit expect_done);
    exp_t e;
    int   err;
    int   ff;
    err = 0;
    ff  = 0;
    for (int k = 0; k < NV; k++) begin
      if (tbl[k*2 +: 2] != golden(4'(k))) begin
        if (err == 0) ff = k;
        err++;
      end
    end
    exp_table[d] = tbl;
    start[d]     = 1'b1;
    c0[d]        = cyc + 1;
    if (expect_done) begin
      e.which    = d;
      e.err      = err;
      e.ff       = ff;
      e.pass     = (err == 0) ? 1 : 0;
      e.fs       = (err != 0) ? 1 : 0;
      e.done_cyc = c0[d] + NV * hold(d);
      sbq.push_back(e);
    end
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (done[d] === 1'b1) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_cleared(input int d, input string tag);
    check({tag, "_busy"}, int'(busy[d]), 0);
    check({tag, "_done"}, int'(done[d]), 0);
    check({tag, "_pass"}, int'(pass[d]), 0);
    check({tag, "_err_cnt"}, int'(err_cnt[d]), 0);
    check({tag, "_first_fail"}, int'(first_fail[d]), 0);
    check({tag, "_fail_seen"}, int'(fail_seen[d]), 0);
    check({tag, "_dut_in"}, int'(dut_in[d]), 0);
  endtask

  // Monitor: step check while busy, scoreboard pop on each done rise
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (busy[d] === 1'b1)
        check("dut_in_step", int'(dut_in[d]), (cyc - c0[d]) / hold(d));
      if (done[d] === 1'b1 && done_q[d] === 1'b0) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("done_which", d, e.which);
          check("err_cnt", int'(err_cnt[d]), e.err);
          check("first_fail", int'(first_fail[d]), e.ff);
          check("pass", int'(pass[d]), e.pass);
          check("fail_seen", int'(fail_seen[d]), e.fs);
          check("busy_at_done", int'(busy[d]), 0);
          check("done_latency", cyc, e.done_cyc);
          check("dut_in_at_done", int'(dut_in[d]), NV - 1);
        end
      end
      done_q[d] = done[d];
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] g;
    logic [31:0] tbl;
    bit          hit;
    g            = golden_table();
    done_q[0]    = 1'b0;
    done_q[1]    = 1'b0;
    c0[0]        = 0;
    c0[1]        = 0;
    start[0]     = 1'b0;
    start[1]     = 1'b0;
    exp_table[0] = g;
    exp_table[1] = g;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared(0, "reset_h2");
    check_cleared(1, "reset_h1");
    rst = 1'b0;
    @(negedge clk);

    // Golden sweep, hold 2
    launch(0, g, 1);
    wait_done(0);

    // Single fault at vector 5, plus fail_seen timing
    launch(0, g ^ (32'h3 << 10), 1);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (fail_seen[0] === 1'b1) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    check("fail_seen_seen", int'(hit), 1);
    check("fail_seen_rise", cyc, c0[0] + 12);
    wait_done(0);

    // All wrong, with a start pulse at E0+9 that must be ignored
    launch(0, ~g, 1);
    while (cyc < c0[0] + 8) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);

    // Restart from DONE clears results at the start edge
    launch(0, g, 1);
    check("restart_done", int'(done[0]), 0);
    check("restart_err_cnt", int'(err_cnt[0]), 0);
    check("restart_busy", int'(busy[0]), 1);
    check("restart_dut_in", int'(dut_in[0]), 0);
    wait_done(0);

    // Mid-sweep reset while dut_in is 7
    launch(0, ~g, 0);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (dut_in[0] === 4'd7) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    check("reached_vec7", int'(hit), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared(0, "midreset");
    repeat (3) @(negedge clk);
    check_cleared(0, "idle_after_reset");
    launch(0, g, 1);
    wait_done(0);

    // Hold 1 build: golden sweep, then fault at vector 15
    launch(1, g, 1);
    wait_done(1);
    launch(1, g ^ (32'h1 << 30), 1);
    wait_done(1);

    // Randomized tables on both builds
    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < 2; d++) begin
        tbl = g;
        for (int k = 0; k < NV; k++)
          if ($urandom_range(0, 3) == 0) tbl[k*2 +: 2] = tbl[k*2 +: 2] ^ 2'($urandom_range(1, 3));
        launch(d, tbl, 1);
        wait_done(d);
      end
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Self-checking stimulus controller for the lab's 4-input, 2-output combinational blocks.
- On a start pulse, steps the DUT inputs through every combination in ascending order, {a,b,c,d} = 0000 to 1111 with a as MSB.
- Holds each vector for a programmable settle time and samples the DUT outputs at the end of it.
- Compares each sample against a golden truth table and reports pass/fail, the error count and the first failing vector.
- Sits between a top-level lab harness and any l2-style combinational block. Replaces hand-written exhaustive benches with one synthesizable sequencer.

Parameters:
- N_IN, 4: number of DUT inputs; the sequencer applies 2**N_IN vectors.
- N_OUT, 2: number of DUT outputs checked per vector.
- HOLD_CYCLES, 2: clock cycles each vector is held before sampling. Minimum 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- exp_table  in  (2**N_IN)*N_OUT  golden outputs; vector k expected at exp_table[k*N_OUT +: N_OUT].
- dut_out  in  N_OUT  DUT outputs, packed {f1,f2} with f1 as MSB.
- dut_in  out  N_IN  applied vector, packed {a,b,c,d}.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until the next start or rst.
- pass  out  1  valid when done=1; high iff err_cnt==0.
- err_cnt  out  N_IN+1  number of mismatching vectors.
- first_fail  out  N_IN  index of the lowest mismatching vector; 0 if there is none.
- fail_seen  out  1  high once any mismatch has been recorded in the current sweep.

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-sweep):
  - State goes to IDLE.
  - dut_in=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, fail_seen=0.
  - Vector and hold counters clear. rst has priority over start.
- FSM states: IDLE, APPLY, DONE.
- IDLE to APPLY, on the edge E0 where start=1:
  - dut_in=0, vector counter=0, hold counter=0.
  - busy=1, done=0, pass=0, err_cnt=0, first_fail=0, fail_seen=0.
- APPLY:
  - dut_in equals the vector counter, unchanged for HOLD_CYCLES cycles.
  - The hold counter increments every cycle.
  - When hold counter == HOLD_CYCLES-1, at that edge:
    - Compare dut_out with the expected slice for the current vector.
    - On mismatch: err_cnt increments. If fail_seen=0, first_fail takes the vector index and fail_seen goes to 1.
    - The hold counter resets to 0.
    - If vector counter < 2**N_IN-1: the vector counter and dut_in increment, and the FSM stays in APPLY.
    - Otherwise: go to DONE, with busy=0, done=1 and pass = (updated err_cnt==0). The last comparison counts toward pass.
- Timing:
  - Vector k is sampled at edge E0 + HOLD_CYCLES*(k+1).
  - done rises at E0 + (2**N_IN)*HOLD_CYCLES. With the defaults that is E0+32.
- DONE:
  - All result outputs hold and dut_in stays at the last vector.
  - start=1 restarts exactly as from IDLE, clearing the results at the same edge.
- start while busy (in APPLY) is ignored; the sweep is not restarted.
- exp_table and dut_out are only read on sample edges. Changes between sample edges have no effect.
- err_cnt cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
- HOLD_CYCLES=1: a new vector every cycle, with the sample taken on the first edge after the vector is applied.

Test Plan:
1. Golden run: behavioural DUT (f1=a^b, f2=c&d), exp_table generated from the same model, HOLD_CYCLES=2, start pulse at E0.
   -> dut_in steps 0..15 every 2 cycles.
   -> done=1 at E0+32 with pass=1, err_cnt=0, fail_seen=0, busy=0.
2. Single fault: flip the expected bits for vector 5 only.
   -> err_cnt=1, first_fail=5, fail_seen=1, pass=0.
   -> fail_seen rises at E0+12.
3. All wrong: exp_table = bitwise inverse of the golden table.
   -> err_cnt=16, first_fail=0, pass=0.
4. Start ignored while busy: pulse start again at E0+9.
   -> Sweep continues unchanged and done still at E0+32.
   -> Then a start in DONE clears done/err_cnt at that edge and rescans from dut_in=0.
5. Mid-sweep reset: assert rst for 1 cycle while dut_in=7.
   -> Next cycle all outputs are 0 and the FSM is in IDLE.
   -> A later start completes a full golden sweep with pass=1.
6. HOLD_CYCLES=1 build: golden run.
   -> done at E0+16.
   -> Injected fault at vector 15 gives err_cnt=1, first_fail=15, and pass=0 on the same edge that done rises.
